ftdi_sync_fifo_datapath: RTL and testbench
==========================================

// Module: ftdi_sync_fifo_datapath
// PURPOSE
//  Byte datapath for the FTDI synchronous-FIFO port, paired with the FTDI interface control FSM.
//  Captures host->FPGA bytes into an RX FIFO and sources FPGA->host bytes from a TX FIFO.
//  Transfers are qualified by the FSM's rd_n/wr_n strobes.
//  Reports rf_almost_full, wf_almost_empty and wf_empty back to the FSM.
//  Exposes valid/ready byte streams to the fabric.
// PARAMETERS
//  RF_DEPTH      16  RX FIFO depth in bytes; power of two, >=4
//  WF_DEPTH      16  TX FIFO depth in bytes; power of two, >=4
//  RF_AF_MARGIN   4  rf_almost_full when free RX slots <= RF_AF_MARGIN; covers FSM latency
//  WF_AE_LEVEL    1  wf_almost_empty when TX level <= WF_AE_LEVEL
// PORTS
//  clk              in   1   FTDI 60 MHz clock; sole clock
//  res_n            in   1   reset, synchronous, active-low
//  rxf_n            in   1   FTDI: RX data available (active-low)
//  txe_n            in   1   FTDI: TX space available (active-low)
//  rd_n, oe_n, wr_n in   1   strobes from the control FSM (registered there)
//  ftdi_data_in     in   8   FTDI data bus, input path
//  ftdi_data_out    out  8   FTDI data bus, output path
//  ftdi_data_oe     out  1   1 = FPGA drives the bus
//  rf_almost_full   out  1   to FSM
//  wf_almost_empty  out  1   to FSM
//  wf_empty         out  1   to FSM
//  rx_data          out  8   fabric RX stream, show-ahead head of RX FIFO
//  rx_valid         out  1   RX FIFO not empty
//  rx_ready         in   1   pop RX when rx_valid & rx_ready
//  tx_data          in   8   fabric TX stream
//  tx_valid         in   1   push TX when tx_valid & tx_ready
//  tx_ready         out  1   TX FIFO not full
//  rf_level         out  $clog2(RF_DEPTH)+1   RX occupancy
//  wf_level         out  $clog2(WF_DEPTH)+1   TX occupancy
//  rf_overflow      out  1   sticky: RX byte dropped, FIFO full
//  wf_underrun      out  1   sticky: write strobe while TX empty
//  err_clear        in   1   one-cycle pulse clears both sticky flags
// BEHAVIOUR
//  Reset (res_n=0 at posedge): pointers/levels 0, sticky flags 0.
//   Resulting outputs: rx_valid=0, tx_ready=1, wf_empty=1, wf_almost_empty=1, rf_almost_full=0.
//   ftdi_data_oe = res_n & ~wr_n, so it is 0 whenever res_n=0. Reset mid-transfer discards FIFO contents.
//  RX push: at posedge when rd_n=0 & rxf_n=0, ftdi_data_in is written to the RX FIFO.
//   Byte appears on rx_data/rx_valid the next cycle (latency 1). oe_n alone never pushes.
//  RX full: push while full -> byte dropped, rf_overflow<=1, pointers unchanged.
//   A pop in the same cycle does not rescue the push (push qualified on pre-edge full).
//  RX pop: rx_valid & rx_ready at posedge advances the read pointer. Push and pop may coincide; level unchanged.
//  TX push: tx_valid & tx_ready at posedge writes tx_data; visible to the FTDI side the next cycle.
//  TX pop: ftdi_data_out = TX head combinationally.
//   At posedge with wr_n=0 & txe_n=0 & !wf_empty, the head is consumed.
//   wr_n=0 with txe_n=1: no pop, data held.
//   wr_n=0 & txe_n=0 & wf_empty: no pop, wf_underrun<=1.
//  Bus direction: ftdi_data_oe=~wr_n (gated by res_n); FPGA releases the bus in all non-write states.
//  Flags are combinational from registered levels:
//   rf_almost_full = rf_level >= RF_DEPTH-RF_AF_MARGIN
//   wf_almost_empty = wf_level <= WF_AE_LEVEL
//   wf_empty = wf_level==0
//  Pointers are $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
//   full = MSBs differ & rest equal; empty = pointers equal.
//  Sticky flags: set dominates err_clear when both occur in the same cycle.
// TESTING
//  1 Reset: hold res_n=0 2 cycles mid-traffic -> rx_valid=0, tx_ready=1, wf_empty=1, levels 0, oe=0.
//  2 RX burst: rxf_n=0, rd_n=0 for 5 cycles, bytes 0x10..0x14, rx_ready=1
//    -> rx_data 0x10..0x14 in order, each 1 cycle after capture.
//  3 RX fill: RF_DEPTH=16, rx_ready=0, rd_n=0 for 18 cycles
//    -> rf_almost_full once rf_level=12; rf_level=16; rf_overflow=1; bytes 17-18 lost.
//  4 TX drain: push 0xA0..0xA3, then wr_n=0, txe_n=0 for 4 cycles
//    -> ftdi_data_out A0..A3, oe=1, wf_empty=1 after last; 5th strobe sets wf_underrun.
//  5 TX stall: wr_n=0 with txe_n=1 for 3 cycles -> no pop, data_out steady, wf_level unchanged.
//  6 Simultaneous: TX push and pop in the same cycle at level 1 -> level stays 1; err_clear clears sticky flags.

Source files
------------

// File: rtl/ftdi_sync_fifo_datapath.sv
// Byte datapath for the FTDI synchronous-FIFO port: RX capture FIFO,
// TX source FIFO, flow-control flags for the control FSM and sticky errors.

module ftdi_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       res_n,
   input  logic                       i_push,
   input  logic [7:0]                 i_wdata,
   input  logic                       i_pop,
   output logic [7:0]                 o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_do_push;
   logic        w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_level = r_wptr - r_rptr;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule

module ftdi_sync_fifo_datapath #(
   parameter int RF_DEPTH     = 16,
   parameter int WF_DEPTH     = 16,
   parameter int RF_AF_MARGIN = 4,
   parameter int WF_AE_LEVEL  = 1
) (
   input  logic                        clk,
   input  logic                        res_n,
   input  logic                        rxf_n,
   input  logic                        txe_n,
   input  logic                        rd_n,
   input  logic                        oe_n,
   input  logic                        wr_n,
   input  logic [7:0]                  ftdi_data_in,
   output logic [7:0]                  ftdi_data_out,
   output logic                        ftdi_data_oe,
   output logic                        rf_almost_full,
   output logic                        wf_almost_empty,
   output logic                        wf_empty,
   output logic [7:0]                  rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [$clog2(RF_DEPTH):0]   rf_level,
   output logic [$clog2(WF_DEPTH):0]   wf_level,
   output logic                        rf_overflow,
   output logic                        wf_underrun,
   input  logic                        err_clear
);

   localparam int RLW = $clog2(RF_DEPTH) + 1;
   localparam int WLW = $clog2(WF_DEPTH) + 1;
   localparam logic [RLW-1:0] RF_AF_TH = RLW'(RF_DEPTH - RF_AF_MARGIN);
   localparam logic [WLW-1:0] WF_AE_TH = WLW'(WF_AE_LEVEL);

   logic w_rf_push;
   logic w_rf_pop;
   logic w_rf_full;
   logic w_rf_empty;
   logic w_wf_push;
   logic w_wf_pop;
   logic w_wf_full;
   logic w_wf_empty;
   logic w_wr_go;
   logic w_ovf_set;
   logic w_und_set;
   logic w_unused;
   logic r_rf_overflow;
   logic r_wf_underrun;

   // Output enable is an FSM concern; data capture depends only on rd_n.
   assign w_unused = oe_n;

   assign w_rf_push = ~rd_n & ~rxf_n;
   assign w_rf_pop  = rx_valid & rx_ready;
   assign w_ovf_set = w_rf_push & w_rf_full;

   ftdi_byte_fifo #(.DEPTH(RF_DEPTH)) u_rf (
      .clk     (clk),
      .res_n   (res_n),
      .i_push  (w_rf_push),
      .i_wdata (ftdi_data_in),
      .i_pop   (w_rf_pop),
      .o_rdata (rx_data),
      .o_full  (w_rf_full),
      .o_empty (w_rf_empty),
      .o_level (rf_level)
   );

   assign w_wr_go   = ~wr_n & ~txe_n;
   assign w_wf_push = tx_valid & tx_ready;
   assign w_wf_pop  = w_wr_go & ~w_wf_empty;
   assign w_und_set = w_wr_go & w_wf_empty;

   ftdi_byte_fifo #(.DEPTH(WF_DEPTH)) u_wf (
      .clk     (clk),
      .res_n   (res_n),
      .i_push  (w_wf_push),
      .i_wdata (tx_data),
      .i_pop   (w_wf_pop),
      .o_rdata (ftdi_data_out),
      .o_full  (w_wf_full),
      .o_empty (w_wf_empty),
      .o_level (wf_level)
   );

   assign rx_valid        = ~w_rf_empty;
   assign tx_ready        = ~w_wf_full;
   assign wf_empty        = w_wf_empty;
   assign rf_almost_full  = (rf_level >= RF_AF_TH);
   assign wf_almost_empty = (wf_level <= WF_AE_TH);
   assign ftdi_data_oe    = res_n & ~wr_n;
   assign rf_overflow     = r_rf_overflow;
   assign wf_underrun     = r_wf_underrun;

   // A new error event in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         r_rf_overflow <= 1'b0;
         r_wf_underrun <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_rf_overflow <= 1'b1;
         end else if (err_clear) begin
            r_rf_overflow <= 1'b0;
         end
         if (w_und_set) begin
            r_wf_underrun <= 1'b1;
         end else if (err_clear) begin
            r_wf_underrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ftdi_sync_fifo_datapath.sv
// Directed table-driven bench for ftdi_sync_fifo_datapath plus
// hand-written sequences for fill, overflow, stall and full/empty corners.

module tb_ftdi_sync_fifo_datapath;

   logic       clk = 1'b0;
   logic       res_n, rxf_n, txe_n, rd_n, oe_n, wr_n;
   logic [7:0] ftdi_data_in, ftdi_data_out;
   logic       ftdi_data_oe, rf_almost_full, wf_almost_empty, wf_empty;
   logic [7:0] rx_data, tx_data;
   logic       rx_valid, rx_ready, tx_valid, tx_ready;
   logic [4:0] rf_level, wf_level;
   logic       rf_overflow, wf_underrun, err_clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ftdi_sync_fifo_datapath #(
      .RF_DEPTH(16), .WF_DEPTH(16), .RF_AF_MARGIN(4), .WF_AE_LEVEL(1)
   ) dut (
      .clk(clk), .res_n(res_n), .rxf_n(rxf_n), .txe_n(txe_n),
      .rd_n(rd_n), .oe_n(oe_n), .wr_n(wr_n),
      .ftdi_data_in(ftdi_data_in), .ftdi_data_out(ftdi_data_out),
      .ftdi_data_oe(ftdi_data_oe), .rf_almost_full(rf_almost_full),
      .wf_almost_empty(wf_almost_empty), .wf_empty(wf_empty),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rf_level(rf_level), .wf_level(wf_level),
      .rf_overflow(rf_overflow), .wf_underrun(wf_underrun),
      .err_clear(err_clear)
   );

   typedef struct {
      logic       res_n, rxf_n, rd_n, oe_n, rx_ready;
      logic [7:0] din;
      logic       txe_n, wr_n, tx_valid;
      logic [7:0] tdat;
      logic       err_clr;
      logic       e_rxv;
      logic [7:0] e_rxd;
      logic [4:0] e_rfl, e_wfl;
      logic [7:0] e_dout;
      logic       e_oe, e_ovf, e_und;
   } vec_t;

   vec_t tbl [21];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      res_n = 1; rxf_n = 1; rd_n = 1; oe_n = 1; rx_ready = 0;
      ftdi_data_in = 0; txe_n = 1; wr_n = 1; tx_valid = 0;
      tx_data = 0; err_clear = 0;
   endtask

   initial begin
      // res rxf rd oe rdy din  txe wr tv tdat clr | rxv rxd rfl wfl dout oe ovf und
      tbl[0]  = '{0,0,0,1,0,8'h55,0,0,1,8'h66,0, 0,8'h00,0,0,8'h00,0,0,0};
      tbl[1]  = '{0,0,0,1,0,8'h55,0,0,1,8'h66,0, 0,8'h00,0,0,8'h00,0,0,0};
      tbl[2]  = '{1,0,0,1,1,8'h10,1,1,0,8'h00,0, 1,8'h10,1,0,8'h00,0,0,0};
      tbl[3]  = '{1,0,0,1,1,8'h11,1,1,0,8'h00,0, 1,8'h11,1,0,8'h00,0,0,0};
      tbl[4]  = '{1,0,0,1,1,8'h12,1,1,0,8'h00,0, 1,8'h12,1,0,8'h00,0,0,0};
      tbl[5]  = '{1,0,0,1,1,8'h13,1,1,0,8'h00,0, 1,8'h13,1,0,8'h00,0,0,0};
      tbl[6]  = '{1,0,0,1,1,8'h14,1,1,0,8'h00,0, 1,8'h14,1,0,8'h00,0,0,0};
      tbl[7]  = '{1,1,1,1,1,8'h00,1,1,0,8'h00,0, 0,8'h00,0,0,8'h00,0,0,0};
      tbl[8]  = '{1,0,1,0,0,8'h77,1,1,0,8'h00,0, 0,8'h00,0,0,8'h00,0,0,0};
      tbl[9]  = '{1,1,0,1,0,8'h78,1,1,0,8'h00,0, 0,8'h00,0,0,8'h00,0,0,0};
      tbl[10] = '{1,1,1,1,0,8'h00,1,1,1,8'hA0,0, 0,8'h00,0,1,8'hA0,0,0,0};
      tbl[11] = '{1,1,1,1,0,8'h00,1,1,1,8'hA1,0, 0,8'h00,0,2,8'hA0,0,0,0};
      tbl[12] = '{1,1,1,1,0,8'h00,1,1,1,8'hA2,0, 0,8'h00,0,3,8'hA0,0,0,0};
      tbl[13] = '{1,1,1,1,0,8'h00,1,1,1,8'hA3,0, 0,8'h00,0,4,8'hA0,0,0,0};
      tbl[14] = '{1,1,1,1,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,3,8'hA1,1,0,0};
      tbl[15] = '{1,1,1,1,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,2,8'hA2,1,0,0};
      tbl[16] = '{1,1,1,1,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,1,8'hA3,1,0,0};
      tbl[17] = '{1,1,1,1,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,0,8'h00,1,0,0};
      tbl[18] = '{1,1,1,1,0,8'h00,0,0,0,8'h00,0, 0,8'h00,0,0,8'h00,1,0,1};
      tbl[19] = '{1,1,1,1,0,8'h00,1,1,0,8'h00,0, 0,8'h00,0,0,8'h00,0,0,1};
      tbl[20] = '{1,1,1,1,0,8'h00,1,1,0,8'h00,1, 0,8'h00,0,0,8'h00,0,0,0};

      idle();
      step();

      for (int i = 0; i < 21; i++) begin
         res_n = tbl[i].res_n; rxf_n = tbl[i].rxf_n; rd_n = tbl[i].rd_n;
         oe_n = tbl[i].oe_n; rx_ready = tbl[i].rx_ready;
         ftdi_data_in = tbl[i].din; txe_n = tbl[i].txe_n;
         wr_n = tbl[i].wr_n; tx_valid = tbl[i].tx_valid;
         tx_data = tbl[i].tdat; err_clear = tbl[i].err_clr;
         step();
         chk($sformatf("v%0d.rx_valid", i), 32'(rx_valid), 32'(tbl[i].e_rxv));
         if (tbl[i].e_rxv)
            chk($sformatf("v%0d.rx_data", i), 32'(rx_data), 32'(tbl[i].e_rxd));
         chk($sformatf("v%0d.rf_level", i), 32'(rf_level), 32'(tbl[i].e_rfl));
         chk($sformatf("v%0d.wf_level", i), 32'(wf_level), 32'(tbl[i].e_wfl));
         if (tbl[i].e_wfl != 0)
            chk($sformatf("v%0d.data_out", i), 32'(ftdi_data_out),
                32'(tbl[i].e_dout));
         chk($sformatf("v%0d.oe", i), 32'(ftdi_data_oe), 32'(tbl[i].e_oe));
         chk($sformatf("v%0d.ovf", i), 32'(rf_overflow), 32'(tbl[i].e_ovf));
         chk($sformatf("v%0d.und", i), 32'(wf_underrun), 32'(tbl[i].e_und));
         chk($sformatf("v%0d.tx_ready", i), 32'(tx_ready),
             32'(tbl[i].e_wfl != 16));
         chk($sformatf("v%0d.wf_empty", i), 32'(wf_empty),
             32'(tbl[i].e_wfl == 0));
         chk($sformatf("v%0d.wf_ae", i), 32'(wf_almost_empty),
             32'(tbl[i].e_wfl <= 1));
         chk($sformatf("v%0d.rf_af", i), 32'(rf_almost_full),
             32'(tbl[i].e_rfl >= 12));
      end

      // RX fill past full: bytes 17 and 18 are dropped
      idle();
      rd_n = 0; rxf_n = 0;
      for (int k = 1; k <= 18; k++) begin
         int lvl;
         ftdi_data_in = 8'(8'h1F + k);
         step();
         lvl = (k > 16) ? 16 : k;
         chk($sformatf("fill%0d.level", k), 32'(rf_level), 32'(lvl));
         chk($sformatf("fill%0d.af", k), 32'(rf_almost_full), 32'(lvl >= 12));
         chk($sformatf("fill%0d.ovf", k), 32'(rf_overflow), 32'(k >= 17));
      end

      // push while full with a concurrent pop: push still dropped
      ftdi_data_in = 8'hEE; rx_ready = 1;
      chk("full_pop.head", 32'(rx_data), 32'h20);
      step();
      chk("full_pop.level", 32'(rf_level), 32'd15);
      rd_n = 1; rxf_n = 1;
      for (int j = 1; j <= 15; j++) begin
         chk($sformatf("drain%0d.rx_data", j), 32'(rx_data), 32'(8'h20 + j));
         step();
      end
      chk("drain.rx_valid", 32'(rx_valid), 32'd0);
      chk("drain.level", 32'(rf_level), 32'd0);
      rx_ready = 0;

      err_clear = 1;
      step();
      err_clear = 0;
      chk("clr.ovf", 32'(rf_overflow), 32'd0);

      // underrun set coinciding with err_clear: set wins
      wr_n = 0; txe_n = 0; err_clear = 1;
      step();
      chk("setdom.und", 32'(wf_underrun), 32'd1);
      wr_n = 1; txe_n = 1; err_clear = 0;

      // TX stall with txe_n high
      tx_valid = 1; tx_data = 8'hB0;
      step();
      tx_data = 8'hB1;
      step();
      tx_valid = 0;
      chk("stall.level0", 32'(wf_level), 32'd2);
      chk("stall.ae0", 32'(wf_almost_empty), 32'd0);
      wr_n = 0; txe_n = 1;
      for (int s = 0; s < 3; s++) begin
         step();
         chk($sformatf("stall%0d.dout", s), 32'(ftdi_data_out), 32'hB0);
         chk($sformatf("stall%0d.level", s), 32'(wf_level), 32'd2);
         chk($sformatf("stall%0d.oe", s), 32'(ftdi_data_oe), 32'd1);
      end
      txe_n = 0;
      step();
      chk("pop1.level", 32'(wf_level), 32'd1);
      chk("pop1.dout", 32'(ftdi_data_out), 32'hB1);
      chk("pop1.ae", 32'(wf_almost_empty), 32'd1);

      // simultaneous push and pop at level 1
      tx_valid = 1; tx_data = 8'hC0;
      step();
      chk("simul.level", 32'(wf_level), 32'd1);
      chk("simul.dout", 32'(ftdi_data_out), 32'hC0);
      wr_n = 1; txe_n = 1;

      // TX fill to full, one extra push refused
      for (int k = 0; k < 15; k++) begin
         tx_data = 8'(8'hD0 + k);
         step();
      end
      chk("txfull.level", 32'(wf_level), 32'd16);
      chk("txfull.ready", 32'(tx_ready), 32'd0);
      tx_data = 8'hFF;
      step();
      chk("txfull.hold", 32'(wf_level), 32'd16);
      tx_valid = 0;
      wr_n = 0; txe_n = 0;
      chk("txd0.dout", 32'(ftdi_data_out), 32'hC0);
      step();
      for (int k = 0; k < 15; k++) begin
         chk($sformatf("txd%0d.dout", k + 1), 32'(ftdi_data_out),
             32'(8'hD0 + k));
         step();
      end
      chk("txd.empty", 32'(wf_empty), 32'd1);
      wr_n = 1; txe_n = 1;

      err_clear = 1;
      step();
      err_clear = 0;
      chk("clr.und", 32'(wf_underrun), 32'd0);

      // reset mid-traffic discards both FIFOs
      rd_n = 0; rxf_n = 0; ftdi_data_in = 8'h99;
      tx_valid = 1; tx_data = 8'h98;
      step();
      chk("pre_rst.rfl", 32'(rf_level), 32'd1);
      chk("pre_rst.wfl", 32'(wf_level), 32'd1);
      res_n = 0; wr_n = 0; txe_n = 0;
      step();
      step();
      chk("rst.rx_valid", 32'(rx_valid), 32'd0);
      chk("rst.tx_ready", 32'(tx_ready), 32'd1);
      chk("rst.wf_empty", 32'(wf_empty), 32'd1);
      chk("rst.rfl", 32'(rf_level), 32'd0);
      chk("rst.wfl", 32'(wf_level), 32'd0);
      chk("rst.oe", 32'(ftdi_data_oe), 32'd0);
      chk("rst.und", 32'(wf_underrun), 32'd0);
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
